// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: micro-step sequencer for the register bank and shared bus.
// One op per accepted start. Each op is broken into bus micro-steps that emit
// one-hot register enables and Y/Z/ALU strobes, one step per clock.
module reg_xfer_ctrl #(
    parameter int NREG  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [IDX_W-1:0] ra,
    input  logic [IDX_W-1:0] rb,
    input  logic [IDX_W-1:0] rc,
    input  logic             stall,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [NREG-1:0]  rin,
    output logic [NREG-1:0]  rout,
    output logic             yin,
    output logic             zin,
    output logic             zlo_out,
    output logic [2:0]       alu_op
);

    localparam logic [2:0] OP_MOVE = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_DONE, S_ERR
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] ra_q, rb_q, rc_q;
    logic             accept;

    // Operands are captured only on the cycle the op is accepted.
    assign accept = start && (state == S_IDLE);

    // State register; clr drops straight back to IDLE, abandoning any op.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Operand latch, loaded on accept and held for the life of the op.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (accept) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
        end
    end

    // Next-state and strobe decode. A stalled step emits nothing and is
    // re-issued whole on the first unstalled cycle.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        rin      = '0;
        rout     = '0;
        yin      = 1'b0;
        zin      = 1'b0;
        zlo_out  = 1'b0;
        alu_op   = 3'd0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nx = (op > OP_NOT) ? S_ERR : S_T1;
            end
            S_T1: begin
                if (!stall) begin
                    rout = ONE << rb_q;
                    if (op_q == OP_MOVE) begin
                        rin      = ONE << ra_q;
                        state_nx = S_DONE;
                    end else if (op_q == OP_NOT) begin
                        // Unary op goes straight through the ALU, no Y load.
                        zin      = 1'b1;
                        alu_op   = op_q;
                        state_nx = S_T3;
                    end else begin
                        yin      = 1'b1;
                        state_nx = S_T2;
                    end
                end
            end
            S_T2: begin
                if (!stall) begin
                    rout     = ONE << rc_q;
                    zin      = 1'b1;
                    alu_op   = op_q;
                    state_nx = S_T3;
                end
            end
            S_T3: begin
                if (!stall) begin
                    zlo_out  = 1'b1;
                    rin      = ONE << ra_q;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                err      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: a step-list model of each op checked every cycle,
// a small register bank + Y/Z/ALU driven by the DUT strobes to check results,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [3:0]  ra = '0, rb = '0, rc = '0;
    logic        stall = 1'b0;
    logic        ready, done, err, yin, zin, zlo_out;
    logic [15:0] rin, rout;
    logic [2:0]  alu_op;

    int vectors = 0;
    int miscompares = 0;

    reg_xfer_ctrl #(.NREG(16), .IDX_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .stall(stall), .ready(ready), .done(done), .err(err), .rin(rin),
        .rout(rout), .yin(yin), .zin(zin), .zlo_out(zlo_out), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    // ---------------- register bank environment ----------------
    logic [31:0] regs [16];
    logic [31:0] yreg, zreg, bus, alu_res;
    logic        pk_en = 1'b0;
    logic [3:0]  pk_i = '0;
    logic [31:0] pk_v = '0;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 16; i++) if (rout[i]) bus = bus | regs[i];
        if (zlo_out) bus = bus | zreg;
    end

    always_comb begin
        case (alu_op)
            3'd1:    alu_res = yreg + bus;
            3'd2:    alu_res = yreg - bus;
            3'd3:    alu_res = yreg & bus;
            3'd4:    alu_res = yreg | bus;
            3'd5:    alu_res = ~bus;
            default: alu_res = bus;
        endcase
    end

    always @(posedge clk) begin
        if (pk_en) regs[pk_i] <= pk_v;
        if (yin) yreg <= bus;
        if (zin) zreg <= alu_res;
        for (int i = 0; i < 16; i++) if (rin[i]) regs[i] <= bus;
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        yin;
        logic        zin;
        logic        zlo;
        logic [2:0]  alu;
    } step_t;

    // Bus steps an op is made of, in order.
    function automatic int nsteps(input logic [2:0] o);
        if (o == 3'd0) return 1;
        if (o == 3'd5) return 2;
        return 3;
    endfunction

    function automatic step_t step_of(input logic [2:0] o, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c,
                                      input int k);
        step_t s;
        s = '0;
        if (o == 3'd0) begin
            s.rout[b] = 1'b1; s.rin[a] = 1'b1;
        end else if (o == 3'd5) begin
            if (k == 0) begin s.rout[b] = 1'b1; s.zin = 1'b1; s.alu = 3'd5; end
            else begin s.zlo = 1'b1; s.rin[a] = 1'b1; end
        end else begin
            if (k == 0)      begin s.rout[b] = 1'b1; s.yin = 1'b1; end
            else if (k == 1) begin s.rout[c] = 1'b1; s.zin = 1'b1; s.alu = o; end
            else             begin s.zlo = 1'b1; s.rin[a] = 1'b1; end
        end
        return s;
    endfunction

    function automatic logic [31:0] result_of(input logic [2:0] o,
                                              input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd1:    return x + y;
            3'd2:    return x - y;
            3'd3:    return x & y;
            3'd4:    return x | y;
            3'd5:    return ~x;
            default: return x;
        endcase
    endfunction

    // m_ph: 0 idle, 1 running step m_k, 2 done pulse, 3 err pulse
    int          m_ph = 0;
    int          m_k = 0;
    logic [2:0]  m_op = '0;
    logic [3:0]  m_ra = '0, m_rb = '0, m_rc = '0;
    logic [31:0] m_exp = '0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_ph <= 0;
            m_k  <= 0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    if (op > 3'd5) m_ph <= 3;
                    else begin
                        m_ph  <= 1;
                        m_k   <= 0;
                        m_op  <= op; m_ra <= ra; m_rb <= rb; m_rc <= rc;
                        m_exp <= result_of(op, regs[rb], regs[rc]);
                    end
                end
                1: if (!stall) begin
                    if (m_k + 1 == nsteps(m_op)) m_ph <= 2;
                    else m_k <= m_k + 1;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    step_t exp_s;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_s = (m_ph == 1 && !stall) ? step_of(m_op, m_ra, m_rb, m_rc, m_k) : '0;
            chk("ready",   {31'd0, ready},   {31'd0, (m_ph == 0)});
            chk("done",    {31'd0, done},    {31'd0, (m_ph == 2)});
            chk("err",     {31'd0, err},     {31'd0, (m_ph == 3)});
            chk("rin",     {16'd0, rin},     {16'd0, exp_s.rin});
            chk("rout",    {16'd0, rout},    {16'd0, exp_s.rout});
            chk("yin",     {31'd0, yin},     {31'd0, exp_s.yin});
            chk("zin",     {31'd0, zin},     {31'd0, exp_s.zin});
            chk("zlo_out", {31'd0, zlo_out}, {31'd0, exp_s.zlo});
            chk("alu_op",  {29'd0, alu_op},  {29'd0, exp_s.alu});
            if (m_ph == 2) chk("result", regs[m_ra], m_exp);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [3:0] i, input logic [31:0] v);
        pk_en = 1'b1; pk_i = i; pk_v = v;
        tick();
        pk_en = 1'b0;
    endtask

    // Present one op for a single cycle; returns with the op in its first step.
    task automatic go(input logic [2:0] o, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c);
        start = 1'b1; op = o; ra = a; rb = b; rc = c;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1 clr = 1'b0;
        for (int i = 0; i < 16; i++) poke(i[3:0], $urandom);
        #1;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst rin",   {16'd0, rin | rout}, 32'd0);
        chk("rst strobes", {26'd0, done, err, yin, zin, zlo_out, (alu_op != 0)}, 32'd0);
        chk_en = 1'b1;
        tick();
        clr = 1'b1;
        tick();

        // MOVE r3 <- r7
        go(3'd0, 4'd3, 4'd7, 4'd0);
        #1;
        chk("move rout", {16'd0, rout}, 32'h0080);
        chk("move rin",  {16'd0, rin},  32'h0008);
        tick(); #1;
        chk("move done", {31'd0, done}, 32'd1);
        chk("move r3",   regs[3], regs[7]);
        tick();

        // ADD r1 <- r2 + r3 with r2=5, r3=10
        poke(4'd2, 32'd5);
        poke(4'd3, 32'd10);
        go(3'd1, 4'd1, 4'd2, 4'd3);
        #1 chk("add t1", {16'd0, rout, 15'd0, yin}, {16'd0, 16'h0004, 16'd1});
        tick(); #1 chk("add t2", {13'd0, rout, zin, alu_op}, {13'd0, 16'h0008, 1'b1, 3'd1});
        tick(); #1 chk("add t3", {15'd0, rin, zlo_out}, {15'd0, 16'h0002, 1'b1});
        tick(); #1 chk("add done", {31'd0, done}, 32'd1);
        chk("add r1", regs[1], 32'd15);
        tick();

        // SUB r4 <- r4 - r5 with a two-cycle stall in T2
        poke(4'd4, 32'd100);
        poke(4'd5, 32'd30);
        go(3'd2, 4'd4, 4'd4, 4'd5);
        tick(); stall = 1'b1;
        #1 chk("sub stall1", {15'd0, rout, zin}, 32'd0);
        tick();
        #1 chk("sub stall2", {12'd0, rout, zin, alu_op}, 32'd0);
        tick(); stall = 1'b0;
        #1 chk("sub t2", {28'd0, zin, alu_op}, {28'd0, 1'b1, 3'd2});
        tick(); tick(); #1;
        chk("sub done", {31'd0, done}, 32'd1);
        chk("sub r4", regs[4], 32'd70);
        tick();

        // Illegal op
        go(3'd7, 4'd1, 4'd2, 4'd3);
        #1 chk("ill err", {30'd0, err, ready}, 32'd2);
        tick(); #1 chk("ill ready", {30'd0, err, ready}, 32'd1);
        tick();

        // start held through NOT r6 <- ~r2 while ra keeps changing
        start = 1'b1; op = 3'd5; ra = 4'd6; rb = 4'd2;
        tick(); ra = 4'd7;
        #1 chk("not t1", {13'd0, rout, zin, alu_op}, {13'd0, 16'h0004, 1'b1, 3'd5});
        tick(); ra = 4'd8;
        #1 chk("not t3 rin", {16'd0, rin}, 32'h0040);
        tick(); ra = 4'd9;
        #1 chk("not done", {31'd0, done}, 32'd1);
        chk("not r6", regs[6], 32'hFFFF_FFFA);
        tick(); ra = 4'd10;
        #1 chk("not relatch ready", {31'd0, ready}, 32'd1);
        tick(); start = 1'b0;
        tick(); #1 chk("relatch rin", {16'd0, rin}, 32'h0400);
        tick(); tick();

        // clr mid-T2 of ADD r9 <- r2 + r3: no write may land
        poke(4'd9, 32'h1234_5678);
        go(3'd1, 4'd9, 4'd2, 4'd3);
        tick();
        #1 clr = 1'b0;
        #1 chk("abort strobes", {14'd0, rin, rout, zin, yin}, 32'd0);
        chk("abort ready", {31'd0, ready}, 32'd1);
        tick(); tick();
        clr = 1'b1;
        tick();
        chk("abort r9", regs[9], 32'h1234_5678);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                : 3'($urandom_range(0, 5));
            ra    = 4'($urandom);
            rb    = 4'($urandom);
            rc    = 4'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 79) != 0);
            tick();
        end
        clr = 1'b1; start = 1'b0; stall = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
